// File: rtl/pwm_pkg.sv
// Shared types and reset-default fade configuration for the pwm block family.
package pwm_pkg;

  // Fade controller states.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRampUp   = 3'd1,
    StHoldHigh = 3'd2,
    StRampDown = 3'd3,
    StHoldLow  = 3'd4
  } pwm_fade_state_e;

  // Reset-default config: lets the fader run from enable alone at mid-scale.
  localparam int unsigned CFG_MIN_DEFAULT  = 0;
  localparam int unsigned CFG_MAX_DEFAULT  = 'h1FF;
  localparam int unsigned CFG_STEP_DEFAULT = 1;
  localparam int unsigned CFG_HOLD_DEFAULT = 0;

endpackage

// File: rtl/pwm_fade_ctrl.sv
// Triangle fade sequencer: steps the pwm compare value up and down between
// configured limits, advancing only on pwm period boundaries.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned STEP_WIDTH    = 4,
  parameter int unsigned HOLD_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     period_start_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [COUNTER_WIDTH-1:0] cfg_min_i,
  input  logic [COUNTER_WIDTH-1:0] cfg_max_i,
  input  logic [STEP_WIDTH-1:0]    cfg_step_i,
  input  logic [HOLD_WIDTH-1:0]    cfg_hold_i,
  output logic [COUNTER_WIDTH-1:0] cmp_value_o,
  output logic                     busy_o,
  output logic                     cycle_done_o
);

  localparam logic [COUNTER_WIDTH-1:0] MinDefault  = COUNTER_WIDTH'(CFG_MIN_DEFAULT);
  localparam logic [COUNTER_WIDTH-1:0] MaxDefault  = COUNTER_WIDTH'(CFG_MAX_DEFAULT);
  localparam logic [STEP_WIDTH-1:0]    StepDefault = STEP_WIDTH'(CFG_STEP_DEFAULT);
  localparam logic [HOLD_WIDTH-1:0]    HoldDefault = HOLD_WIDTH'(CFG_HOLD_DEFAULT);

  pwm_fade_state_e            state_q, state_d;
  logic [COUNTER_WIDTH-1:0]   cmp_q, cmp_d;
  logic [HOLD_WIDTH-1:0]      cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;
  logic                       ready_q, ready_d;
  logic [COUNTER_WIDTH-1:0]   cfg_min_q, cfg_min_d;
  logic [COUNTER_WIDTH-1:0]   cfg_max_q, cfg_max_d;
  logic [STEP_WIDTH-1:0]      cfg_step_q, cfg_step_d;
  logic [HOLD_WIDTH-1:0]      cfg_hold_q, cfg_hold_d;

  logic                       accept;
  logic [COUNTER_WIDTH-1:0]   san_min;
  logic [STEP_WIDTH-1:0]      san_step;
  logic [COUNTER_WIDTH:0]     step_ext;
  logic [COUNTER_WIDTH:0]     up_sum;
  logic [COUNTER_WIDTH:0]     down_floor;
  logic [COUNTER_WIDTH-1:0]   up_next;
  logic [COUNTER_WIDTH-1:0]   down_next;

  assign accept   = cfg_valid_i & ready_q;
  // Inverted limits collapse to a flat level; a zero step would never finish.
  assign san_min  = (cfg_min_i > cfg_max_i) ? cfg_max_i : cfg_min_i;
  assign san_step = (cfg_step_i == '0) ? STEP_WIDTH'(1) : cfg_step_i;

  // Ramp arithmetic is one bit wider so saturation happens before any wrap.
  assign step_ext   = (COUNTER_WIDTH + 1)'(cfg_step_q);
  assign up_sum     = {1'b0, cmp_q} + step_ext;
  assign down_floor = {1'b0, cfg_min_q} + step_ext;
  assign up_next    = (up_sum >= {1'b0, cfg_max_q}) ? cfg_max_q : up_sum[COUNTER_WIDTH-1:0];
  assign down_next  = ({1'b0, cmp_q} < down_floor) ? cfg_min_q :
                      (cmp_q - step_ext[COUNTER_WIDTH-1:0]);

  // Next-state: config capture any cycle in idle, sequencing only on period_start.
  always_comb begin
    state_d    = state_q;
    cmp_d      = cmp_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    cfg_min_d  = cfg_min_q;
    cfg_max_d  = cfg_max_q;
    cfg_step_d = cfg_step_q;
    cfg_hold_d = cfg_hold_q;

    if (accept) begin
      cfg_min_d  = san_min;
      cfg_max_d  = cfg_max_i;
      cfg_step_d = san_step;
      cfg_hold_d = cfg_hold_i;
    end

    if (period_start_i) begin
      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_d = StRampUp;
            cmp_d   = cfg_min_d;  // a same-cycle config applies first
          end
        end
        StRampUp: begin
          cmp_d = up_next;
          if (up_next == cfg_max_q) begin
            state_d = StHoldHigh;
            cnt_d   = cfg_hold_q;
          end
        end
        StHoldHigh: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_WIDTH'(1);
          end else begin
            state_d = StRampDown;
          end
        end
        StRampDown: begin
          cmp_d = down_next;
          if (down_next == cfg_min_q) begin
            state_d = StHoldLow;
            cnt_d   = cfg_hold_q;
          end
        end
        StHoldLow: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_WIDTH'(1);
          end else begin
            done_d = 1'b1;
            if (enable_i) begin
              state_d = StRampUp;
            end else begin
              state_d = StIdle;
              cmp_d   = '0;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cmp_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
  end

  // State and config registers with synchronous reset to the package defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmp_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      cfg_min_q  <= MinDefault;
      cfg_max_q  <= MaxDefault;
      cfg_step_q <= StepDefault;
      cfg_hold_q <= HoldDefault;
    end else begin
      state_q    <= state_d;
      cmp_q      <= cmp_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      cfg_min_q  <= cfg_min_d;
      cfg_max_q  <= cfg_max_d;
      cfg_step_q <= cfg_step_d;
      cfg_hold_q <= cfg_hold_d;
    end
  end

  assign cmp_value_o  = cmp_q;
  assign busy_o       = busy_q;
  assign cycle_done_o = done_q;
  assign cfg_ready_o  = ready_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: a trajectory-list reference model queues
// the expected outputs for every clock; a monitor pops and compares them.
module tb_pwm_fade_ctrl;

  localparam int CW = 10;
  localparam int SW = 4;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_i = 1'b0;
  logic          period_start_i = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [CW-1:0] cfg_min_i = '0;
  logic [CW-1:0] cfg_max_i = '0;
  logic [SW-1:0] cfg_step_i = '0;
  logic [HW-1:0] cfg_hold_i = '0;
  logic [CW-1:0] cmp_value_o;
  logic          busy_o;
  logic          cycle_done_o;

  pwm_fade_ctrl #(
    .COUNTER_WIDTH (CW),
    .STEP_WIDTH    (SW),
    .HOLD_WIDTH    (HW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .period_start_i (period_start_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_min_i      (cfg_min_i),
    .cfg_max_i      (cfg_max_i),
    .cfg_step_i     (cfg_step_i),
    .cfg_hold_i     (cfg_hold_i),
    .cmp_value_o    (cmp_value_o),
    .busy_o         (busy_o),
    .cycle_done_o   (cycle_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A fade cycle is precomputed as the list of compare values seen after each
  // period_start; the cycle ends (cycle_done) when that list runs out.
  int m_min = 0, m_max = 'h1FF, m_step = 1, m_hold = 0;
  bit m_idle = 1'b1;
  int m_cmp = 0;
  bit m_done = 1'b0;
  int traj[$];

  function automatic void build(bit with_start);
    int v;
    traj.delete();
    v = m_min;
    if (with_start) traj.push_back(v);
    do begin
      v = (v + m_step > m_max) ? m_max : v + m_step;
      traj.push_back(v);
    end while (v < m_max);
    repeat (m_hold + 1) traj.push_back(m_max);
    do begin
      v = (v - m_step < m_min) ? m_min : v - m_step;
      traj.push_back(v);
    end while (v > m_min);
    repeat (m_hold + 1) traj.push_back(m_min);
  endfunction

  function automatic void model_step(bit r, bit en, bit ps, bit v, int mn, int mx, int st,
                                     int hd);
    m_done = 1'b0;
    if (r) begin
      m_min = 0; m_max = 'h1FF; m_step = 1; m_hold = 0;
      m_idle = 1'b1; m_cmp = 0; traj.delete();
    end else begin
      if (m_idle && v) begin
        m_max  = mx;
        m_min  = (mn > mx) ? mx : mn;
        m_step = (st == 0) ? 1 : st;
        m_hold = hd;
      end
      if (ps) begin
        if (m_idle) begin
          if (en) begin
            m_idle = 1'b0;
            build(1'b1);
            m_cmp = traj.pop_front();
          end
        end else begin
          m_cmp = traj.pop_front();
          if (traj.size() == 0) begin
            m_done = 1'b1;
            if (en) build(1'b0);
            else begin
              m_idle = 1'b1;
              m_cmp  = 0;
            end
          end
        end
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int cmp;
    bit busy;
    bit done;
    bit ready;
  } exp_t;
  exp_t sb[$];

  // Captures of the DUT right after each period_start, for directed sequences.
  int cap_cmp[$];
  int cap_done[$];

  int c_min = 0, c_max = 0, c_step = 0, c_hold = 0;

  task automatic drive(bit r, bit en, bit ps, bit v);
    exp_t e;
    @(negedge clk);
    rst            = r;
    enable_i       = en;
    period_start_i = ps;
    cfg_valid_i    = v;
    cfg_min_i      = CW'(c_min);
    cfg_max_i      = CW'(c_max);
    cfg_step_i     = SW'(c_step);
    cfg_hold_i     = HW'(c_hold);
    model_step(r, en, ps, v, c_min, c_max, c_step, c_hold);
    e.cmp = m_cmp; e.busy = !m_idle; e.done = m_done; e.ready = m_idle;
    sb.push_back(e);
    @(posedge clk);
    #2;
    if (ps && !r) begin
      cap_cmp.push_back(int'(cmp_value_o));
      cap_done.push_back(int'(cycle_done_o));
    end
  endtask

  task automatic set_cfg(int mn, int mx, int st, int hd);
    c_min = mn; c_max = mx; c_step = st; c_hold = hd;
  endtask

  task automatic periods(int n, bit en, int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, en, 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) drive(1'b0, en, 1'b0, 1'b0);
    end
  endtask

  // Monitor: one expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cmp_value", 32'(cmp_value_o), 32'(e.cmp));
        chk("busy", 32'(busy_o), 32'(e.busy));
        chk("cycle_done", 32'(cycle_done_o), 32'(e.done));
        chk("cfg_ready", 32'(cfg_ready_o), 32'(e.ready));
      end
    end
  end

  initial begin
    int exp_norm[9] = '{0, 4, 8, 8, 8, 4, 0, 0, 0};
    int exp_sat[7]  = '{0, 4, 8, 10, 10, 6, 2};
    int ndone;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Normal cycle with a directed value sequence.
    set_cfg(0, 8, 4, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cap_cmp.delete(); cap_done.delete();
    periods(9, 1'b1, 2);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("normal_cmp[%0d]", i), 32'(cap_cmp[i]), 32'(exp_norm[i]));
      chk($sformatf("normal_done[%0d]", i), 32'(cap_done[i]), (i == 8) ? 32'd1 : 32'd0);
    end
    periods(20, 1'b0, 1);
    chk("normal_idle_ready", 32'(cfg_ready_o), 32'd1);

    // Saturation at max=10 with step 4.
    set_cfg(0, 10, 4, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cap_cmp.delete(); cap_done.delete();
    periods(7, 1'b1, 0);
    for (int i = 0; i < 7; i++)
      chk($sformatf("sat_cmp[%0d]", i), 32'(cap_cmp[i]), 32'(exp_sat[i]));
    periods(10, 1'b0, 0);

    // Degenerate config: step 0, min above max.
    set_cfg(5, 3, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cap_cmp.delete(); cap_done.delete();
    periods(12, 1'b1, 1);
    foreach (cap_cmp[i]) chk($sformatf("degen_cmp[%0d]", i), 32'(cap_cmp[i]), 32'd3);
    periods(10, 1'b0, 1);

    // Graceful stop: enable dropped during the ramp-up.
    set_cfg(2, 20, 3, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cap_cmp.delete(); cap_done.delete();
    periods(3, 1'b1, 1);
    periods(40, 1'b0, 1);
    ndone = 0;
    foreach (cap_done[i]) ndone += cap_done[i];
    chk("graceful_done_count", 32'(ndone), 32'd1);
    chk("graceful_cmp_zero", 32'(cmp_value_o), 32'd0);
    chk("graceful_ready", 32'(cfg_ready_o), 32'd1);

    // Strobe gating: mid-fade then in idle, period_start held low.
    set_cfg(0, 8, 4, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    periods(3, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      set_cfg($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 15),
              $urandom_range(0, 3));
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end
    periods(20, 1'b0, 0);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

    // Reset while holding high, then run on restored defaults (step 1).
    set_cfg(0, 8, 4, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    periods(4, 1'b1, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    cap_cmp.delete(); cap_done.delete();
    periods(5, 1'b1, 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("post_reset_cmp[%0d]", i), 32'(cap_cmp[i]), 32'(i));
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_cfg($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 15),
              $urandom_range(0, 3));
      drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 10; the width of the compare value driven into the pwm block.
REQ-002 SHALL have parameter STEP_WIDTH, default 4; the width of the per-period duty increment.
REQ-003 SHALL have parameter HOLD_WIDTH, default 8; the width of the hold-period count.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable_i  in  1  run fade cycles.
- period_start_i  in  1  one-cycle pulse from pwm period_start_o.
- cfg_valid_i  in  1  config offered.
- cfg_ready_o  out  1  config accepted this cycle if valid.
- cfg_min_i  in  COUNTER_WIDTH  lowest duty.
- cfg_max_i  in  COUNTER_WIDTH  highest duty.
- cfg_step_i  in  STEP_WIDTH  duty change per period.
- cfg_hold_i  in  HOLD_WIDTH  extra periods held at each extreme.
- cmp_value_o  out  COUNTER_WIDTH  drives pwm cmp_value_i.
- busy_o  out  1  state not IDLE.
- cycle_done_o  out  1  one-cycle pulse at end of a full fade cycle.

Function
REQ-006 SHALL implement the states IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN and HOLD_LOW.
REQ-007 SHALL change state, cmp_value_o and the hold counter only on cycles where period_start_i=1; the only exception is reset.
REQ-008 SHALL drive cfg_ready_o=1 only in IDLE; on valid&&ready it latches min, max, step and hold into the config registers.
REQ-009 SHALL store step=0 as 1 and store min as max when cfg_min_i>cfg_max_i, both at acceptance.
REQ-010 IDLE: cmp_value_o=0; with enable_i=1 at period_start it SHALL go to RAMP_UP with cmp=min.
- A config handshake in that same cycle SHALL take effect first, so the new min applies.
REQ-011 RAMP_UP: each period_start SHALL set cmp=min(cmp+step, max), computed COUNTER_WIDTH+1 bits wide with no wrap.
- On reaching max it SHALL go to HOLD_HIGH and load the hold counter with hold.
REQ-012 HOLD_HIGH: at period_start with counter≠0 it SHALL decrement; with counter=0 it SHALL go to RAMP_DOWN with cmp unchanged.
- hold=0 therefore means one period at max after the ramp step.
REQ-013 RAMP_DOWN: each period_start SHALL set cmp=max(cmp−step, min), with no underflow.
- On reaching min it SHALL go to HOLD_LOW and load the counter with hold.
REQ-014 HOLD_LOW: at counter=0 it SHALL pulse cycle_done_o for exactly one clk.
- Then enable_i=1 → RAMP_UP with cmp unchanged (=min); enable_i=0 → IDLE with cmp=0.
REQ-015 SHALL ignore deassertion of enable_i outside IDLE and HOLD_LOW expiry: the current cycle completes gracefully.
REQ-016 SHALL pass through the ramp states in one period when min=max: RAMP_UP reaches max on the first step.
REQ-017 SHALL drive busy_o=1 in every state except IDLE, and all outputs directly from registers.

Reset
REQ-018 On rst=1 at a clk edge, the following SHALL be set:
- state=IDLE, cmp_value_o=0, counter=0, cycle_done_o=0, busy_o=0.
- cfg min=0, max=10'h1FF (mid-scale), step=1, hold=0.
REQ-019 Because of those defaults, SHALL run with enable_i alone; reset mid-fade SHALL abandon the cycle at the next edge.

Structure
REQ-020 SHALL take the pwm_fade_state_e enum and the reset-default config constants from the shared package pwm_pkg.
REQ-021 SHALL contain no sub-module; it is instantiated beside pwm, with period_start_o looped back and cmp_value_o driving cmp_value_i.

Verification
REQ-022 SHALL cover these directed scenarios, with COUNTER_WIDTH=10 unless stated:
- Normal cycle: cfg min=0, max=8, step=4, hold=1, enable=1 → cmp at successive period_starts 0,4,8,8,8,4,0,0,0; cycle_done_o pulses once at the 9th.
- Saturation: min=0, max=10, step=4 → ramp 0,4,8,10, then 6,2,0; never exceeds 10 or wraps below 0.
- Degenerate config: step=0, min=5, max=3 → stored step=1, min=3; cmp stays 3 each cycle.
- Graceful stop: drop enable_i during RAMP_UP → the cycle completes; cycle_done_o pulses; then IDLE, cmp=0, cfg_ready_o=1.
- Strobe gating: toggle enable_i and cfg_valid_i with period_start_i held 0 → cmp_value_o and state never change.
- Reset mid-fade: rst in HOLD_HIGH → next edge IDLE, cmp=0, config restored to max=0x1FF, step=1.
